// File: rtl/ntt_wb_addr_seq_k2_pkg.sv
// Shared types for the k2-stage write-back path: address pair, FSM state, counter width.
package ntt_wb_pkg;
  // Address width is codebase-wide; NUM_PAIRS default is 1<<(radix_k1*k).
  localparam int WB_D_WIDTH   = 10;
  localparam int WB_NUM_PAIRS = 8;
  localparam int CNT_W        = $clog2(WB_NUM_PAIRS) + 1;

  typedef struct packed {
    logic [WB_D_WIDTH-1:0] addr0;
    logic [WB_D_WIDTH-1:0] addr1;
  } addr_pair_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } wb_state_t;
endpackage

// File: rtl/ntt_wb_addr_seq_k2_if.sv
// AGU / butterfly / memory-write bundle of the k2 write-back sequencer.
interface ntt_wb_addr_seq_k2_if import ntt_wb_pkg::*; #(
  parameter int D_WIDTH = WB_D_WIDTH,
  parameter int DATA_W  = 64
) ();
  logic               start_i;
  logic               agu_en_i;
  logic [D_WIDTH-1:0] order0_i;
  logic [D_WIDTH-1:0] order1_i;
  logic               bf_valid_i;
  logic [DATA_W-1:0]  bf_d0_i;
  logic [DATA_W-1:0]  bf_d1_i;
  logic               mem_we_o;
  logic [D_WIDTH-1:0] mem_wa0_o;
  logic [D_WIDTH-1:0] mem_wa1_o;
  logic [DATA_W-1:0]  mem_wd0_o;
  logic [DATA_W-1:0]  mem_wd1_o;
  logic               busy_o;
  logic               done_o;
  logic               ovf_o;
  logic               unf_o;

  modport master (
    output start_i, agu_en_i, order0_i, order1_i, bf_valid_i, bf_d0_i, bf_d1_i,
    input  mem_we_o, mem_wa0_o, mem_wa1_o, mem_wd0_o, mem_wd1_o, busy_o, done_o, ovf_o, unf_o
  );
  modport slave (
    input  start_i, agu_en_i, order0_i, order1_i, bf_valid_i, bf_d0_i, bf_d1_i,
    output mem_we_o, mem_wa0_o, mem_wa1_o, mem_wd0_o, mem_wd1_o, busy_o, done_o, ovf_o, unf_o
  );
endinterface

// File: rtl/ntt_wb_addr_seq_k2_addr_pair_fifo.sv
// Synchronous address-pair FIFO; the caller never pushes when full without a pop, nor pops when empty.
module addr_pair_fifo import ntt_wb_pkg::*; #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  addr_pair_t i_data,
  output addr_pair_t o_data,
  output logic       o_full,
  output logic       o_empty
);
  localparam int AW = $clog2(DEPTH);

  addr_pair_t    r_mem [DEPTH];
  logic [AW:0]   r_wp, r_rp;

  // Extra MSB is the wrap bit separating full from empty.
  assign o_empty = (r_wp == r_rp);
  assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign o_data  = r_mem[r_rp[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + 1'b1;
      if (i_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wp[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/ntt_wb_addr_seq_k2.sv
// k2 write-back sequencer: queues AGU address pairs, re-pairs them with butterfly results, issues writes.
module ntt_wb_addr_seq_k2 import ntt_wb_pkg::*; #(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int NUM_PAIRS  = WB_NUM_PAIRS
) (
  input  logic               clk,
  input  logic               rst,
  ntt_wb_addr_seq_k2_if.slave bus
);
  localparam int            CW   = $clog2(NUM_PAIRS) + 1;
  localparam logic [CW-1:0] NP   = CW'(NUM_PAIRS);
  localparam logic [CW-1:0] LAST = CW'(NUM_PAIRS - 1);

  wb_state_t             r_state;
  logic [CW-1:0]         r_push_cnt, r_wr_cnt;
  logic                  r_ovf, r_unf, r_we;
  logic [WB_D_WIDTH-1:0] r_wa0, r_wa1;
  logic [DATA_W-1:0]     r_wd0, r_wd1;

  logic       w_act, w_push_req, w_push, w_pop, w_full, w_empty, w_last, w_arm;
  addr_pair_t w_head, w_in;

  assign w_act      = (r_state == RUN) || (r_state == DRAIN);
  assign w_arm      = (r_state == IDLE) && bus.start_i;
  // Pairs past NUM_PAIRS still count toward nothing; overflowed pairs still count.
  assign w_push_req = bus.agu_en_i && (r_state == RUN) && (r_push_cnt < NP);
  assign w_pop      = bus.bf_valid_i && !w_empty && w_act;
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_last     = w_pop && (r_wr_cnt == LAST);
  assign w_in       = '{addr0: bus.order0_i, addr1: bus.order1_i};

  addr_pair_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_in),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (bus.start_i) r_state <= RUN;
        RUN:     if (w_last) r_state <= DONE;
                 else if (r_push_cnt == NP) r_state <= DRAIN;
        DRAIN:   if (w_last) r_state <= DONE;
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_push_cnt <= '0;
      r_wr_cnt   <= '0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else if (w_arm) begin
      r_push_cnt <= '0;
      r_wr_cnt   <= '0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      if (w_push_req)                        r_push_cnt <= r_push_cnt + 1'b1;
      if (w_pop)                             r_wr_cnt   <= r_wr_cnt + 1'b1;
      if (w_push_req && w_full && !w_pop)    r_ovf      <= 1'b1;
      if (bus.bf_valid_i && w_empty && w_act) r_unf     <= 1'b1;
    end
  end

  // Write register: address/data hold between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we  <= 1'b0;
      r_wa0 <= '0;
      r_wa1 <= '0;
      r_wd0 <= '0;
      r_wd1 <= '0;
    end else begin
      r_we <= w_pop;
      if (w_pop) begin
        r_wa0 <= w_head.addr0;
        r_wa1 <= w_head.addr1;
        r_wd0 <= bus.bf_d0_i;
        r_wd1 <= bus.bf_d1_i;
      end
    end
  end

  assign bus.mem_we_o  = r_we;
  assign bus.mem_wa0_o = r_wa0;
  assign bus.mem_wa1_o = r_wa1;
  assign bus.mem_wd0_o = r_wd0;
  assign bus.mem_wd1_o = r_wd1;
  assign bus.busy_o    = (r_state != IDLE);
  assign bus.done_o    = (r_state == DONE);
  assign bus.ovf_o     = r_ovf;
  assign bus.unf_o     = r_unf;
endmodule

// File: tb/tb_ntt_wb_addr_seq_k2.sv
// Scoreboard bench: queue-based stage model predicts writes; a negedge monitor checks them.
module tb_ntt_wb_addr_seq_k2;
  import ntt_wb_pkg::*;
  localparam int N = 8, DEPTH = 4, DW = 64, AW = WB_D_WIDTH;

  typedef struct { logic [AW-1:0] a0, a1; logic [DW-1:0] d0, d1; logic done; } wr_t;
  typedef struct { logic [AW-1:0] a0, a1; } pr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ntt_wb_addr_seq_k2_if #(.D_WIDTH(AW), .DATA_W(DW)) bus ();
  ntt_wb_addr_seq_k2 #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .NUM_PAIRS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int  n_cmp = 0, n_bad = 0;
  wr_t exp_q[$];
  pr_t m_q[$];
  bit  m_run, m_donest, m_ovf, m_unf;
  int  m_push, m_wr;
  wr_t last, e;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every write must match the next predicted write; idle cycles must hold the last one.
  always @(negedge clk) begin
    if (rst) begin
      last = '{a0: '0, a1: '0, d0: '0, d1: '0, done: 1'b0};
    end else if (bus.mem_we_o) begin
      if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("write", {bus.mem_wa0_o, bus.mem_wa1_o, bus.mem_wd0_o, bus.mem_wd1_o, bus.done_o},
                     {e.a0, e.a1, e.d0, e.d1, e.done});
        last = e;
      end
    end else begin
      chk("idle_hold", {bus.mem_wa0_o, bus.mem_wa1_o, bus.mem_wd0_o, bus.mem_wd1_o, bus.done_o},
                       {last.a0, last.a1, last.d0, last.d1, 1'b0});
    end
  end

  // One clock of stimulus; the model applies the stage rules to the same inputs.
  task automatic step(input bit st, input bit en, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input bit bv);
    int occ;
    bit pop;
    pr_t p;
    logic [DW-1:0] d0, d1;
    d0 = {$urandom, $urandom};
    d1 = {$urandom, $urandom};
    bus.start_i = st; bus.agu_en_i = en; bus.order0_i = a0; bus.order1_i = a1;
    bus.bf_valid_i = bv; bus.bf_d0_i = d0; bus.bf_d1_i = d1;
    if (m_run) begin
      occ = m_q.size();
      pop = bv && occ > 0;
      if (bv && occ == 0) m_unf = 1;
      if (pop) begin
        p = m_q.pop_front();
        m_wr++;
        exp_q.push_back('{a0: p.a0, a1: p.a1, d0: d0, d1: d1, done: (m_wr == N)});
        if (m_wr == N) begin m_run = 0; m_donest = 1; end
      end
      if (en && m_push < N) begin
        m_push++;
        if (occ < DEPTH || pop) m_q.push_back('{a0: a0, a1: a1});
        else m_ovf = 1;
      end
    end else if (m_donest) begin
      m_donest = 0;
    end else if (st) begin
      m_run = 1; m_push = 0; m_wr = 0; m_ovf = 0; m_unf = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1 chk("reset_outputs",
           {bus.mem_we_o, bus.mem_wa0_o, bus.mem_wa1_o, bus.mem_wd0_o, bus.mem_wd1_o,
            bus.busy_o, bus.done_o, bus.ovf_o, bus.unf_o}, 0);
    bus.start_i = 0; bus.agu_en_i = 0; bus.bf_valid_i = 0;
    bus.order0_i = '0; bus.order1_i = '0; bus.bf_d0_i = '0; bus.bf_d1_i = '0;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    exp_q.delete(); m_q.delete();
    m_run = 0; m_donest = 0; m_ovf = 0; m_unf = 0; m_push = 0; m_wr = 0;
  endtask

  task automatic check_end(input string nm);
    step(0, 0, '0, '0, 0);
    step(0, 0, '0, '0, 0);
    chk({nm, "_flags"}, {bus.busy_o, bus.ovf_o, bus.unf_o}, {m_run || m_donest, m_ovf, m_unf});
    chk({nm, "_pending"}, exp_q.size(), 0);
  endtask

  // AGU k2 pattern: en for n_en cycles (order 2c/2c+1), bf_valid for n_bv cycles from bv_at.
  task automatic run_pat(input int n_en, input int bv_at, input int n_bv, input int n_cyc);
    bit en, bv;
    step(1, 0, '0, '0, 0);
    for (int c = 0; c < n_cyc; c++) begin
      en = (c < n_en);
      bv = (c >= bv_at) && (c < bv_at + n_bv);
      step(0, en, AW'(2 * c), AW'(2 * c + 1), bv);
    end
  endtask

  initial begin
    bit st, en, bv, legal;
    bus.start_i = 0; bus.agu_en_i = 0; bus.bf_valid_i = 0;
    bus.order0_i = '0; bus.order1_i = '0; bus.bf_d0_i = '0; bus.bf_d1_i = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    run_pat(N, 3, N, 24);          check_end("nominal");
    run_pat(N + 2, 3, N, 24);      check_end("trailing");
    run_pat(N, 6, N - 2, 24);      check_end("backpressure");
    do_reset();
    run_pat(N, 4, N, 20);          check_end("full_push_pop");
    run_pat(0, 0, 2, 4);           check_end("underflow");
    do_reset();
    run_pat(N, 3, N, 9);
    do_reset();
    run_pat(N, 3, N, 24);          check_end("after_reset");

    for (int s = 0; s < 6; s++) begin
      legal = (s < 4);
      step(1, 0, '0, '0, 0);
      for (int c = 0; c < 120; c++) begin
        st = ($urandom_range(0, 99) < 3);
        en = ($urandom_range(0, 99) < 60);
        bv = legal ? (m_q.size() > 0 && $urandom_range(0, 99) < 55) : ($urandom_range(0, 99) < 50);
        step(st, en, AW'($urandom), AW'($urandom), bv);
      end
      check_end("random");
      if (!legal || m_run || m_donest) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
